// File: rtl/isqrt_pipe_with_valid_pkg.sv
// isqrt_pkg: shared sizing helpers and stage payload type for the pipelined integer square root.
// Downstream delay lines size their depth from isqrt_latency() so operands stay aligned with roots.
package isqrt_pkg;

    localparam int ISQRT_WIDTH = 32;

    function automatic int isqrt_latency(input int width);
        return width / 2;
    endfunction

    function automatic int isqrt_root_w(input int width);
        return width / 2;
    endfunction

    // Two guard bits above the root width hold the shifted-in radicand pair without loss.
    function automatic int isqrt_rem_w(input int width);
        return width / 2 + 2;
    endfunction

    localparam int ISQRT_ROOT_W = isqrt_root_w(ISQRT_WIDTH);
    localparam int ISQRT_REM_W  = isqrt_rem_w(ISQRT_WIDTH);

    typedef struct packed {
        logic [ISQRT_WIDTH-1:0]  rad;
        logic [ISQRT_REM_W-1:0]  rem;
        logic [ISQRT_ROOT_W-1:0] root;
    } isqrt_stage_t;

endpackage

// File: rtl/isqrt_pipe_with_valid_stage.sv
// isqrt_stage: one restoring square-root digit step followed by its valid-gated register.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   vld_i           incoming transfer is valid; data registers load only when set
//   rad_i/rem_i/root_i   radicand (consumed from the top two bits), partial remainder, partial root
//   vld_o/rad_o/rem_o/root_o   registered stage results
module isqrt_stage
    import isqrt_pkg::*;
#(
    parameter int width = ISQRT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            vld_i,
    input  logic [width-1:0]                rad_i,
    input  logic [isqrt_rem_w(width)-1:0]   rem_i,
    input  logic [isqrt_root_w(width)-1:0]  root_i,
    output logic                            vld_o,
    output logic [width-1:0]                rad_o,
    output logic [isqrt_rem_w(width)-1:0]   rem_o,
    output logic [isqrt_root_w(width)-1:0]  root_o
);

    localparam int ROOT_W = isqrt_root_w(width);
    localparam int REM_W  = isqrt_rem_w(width);

    typedef struct packed {
        logic [width-1:0]  rad;
        logic [REM_W-1:0]  rem;
        logic [ROOT_W-1:0] root;
    } payload_t;

    payload_t           pl_d, pl_q;
    logic               vld_q;
    logic [REM_W-1:0]   r2, trial;
    logic               fit;
    logic               unused_hi;

    // Entering stage k the remainder is at most 2*root < 2^(k+1), so its top two bits are
    // always zero and dropping them before the shift loses nothing; likewise root's MSB.
    assign r2        = {rem_i[REM_W-3:0], rad_i[width-1 -: 2]};
    assign trial     = {root_i, 2'b01};
    assign fit       = r2 >= trial;
    assign unused_hi = ^{rem_i[REM_W-1 -: 2], root_i[ROOT_W-1]};

    always_comb begin
        pl_d.rad  = {rad_i[width-3:0], 2'b00};
        pl_d.rem  = fit ? r2 - trial : r2;
        pl_d.root = {root_i[ROOT_W-2:0], fit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            pl_q  <= '0;
        end else begin
            vld_q <= vld_i;
            if (vld_i) pl_q <= pl_d;
        end
    end

    assign vld_o  = vld_q;
    assign rad_o  = pl_q.rad;
    assign rem_o  = pl_q.rem;
    assign root_o = pl_q.root;

endmodule

// File: rtl/isqrt_pipe_with_valid.sv
// isqrt_pipe_with_valid: fully pipelined floor(sqrt(x)) with a travelling valid bit, latency width/2.
// Ports:
//   clk, rst    clock, asynchronous active-high reset (clears every stage)
//   in_vld      in_data is a valid radicand this cycle (no backpressure)
//   in_data     unsigned radicand, width bits
//   out_vld     out_data holds a valid result this cycle
//   out_data    floor(sqrt(radicand)), width/2 bits; holds the last valid result during bubbles
//   out_rem     radicand - out_data^2, width/2+1 bits; only when ISQRT_REMAINDER_EN is defined
module isqrt_pipe_with_valid
    import isqrt_pkg::*;
#(
    parameter int width = ISQRT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [width-1:0]     in_data,
`ifdef ISQRT_REMAINDER_EN
    output logic [width/2:0]     out_rem,
`endif
    output logic                 out_vld,
    output logic [width/2-1:0]   out_data
);

    localparam int n_stages = isqrt_latency(width);
    localparam int ROOT_W   = isqrt_root_w(width);
    localparam int REM_W    = isqrt_rem_w(width);

    // Index 0 is the pipe input, index k+1 is the registered output of stage k.
    logic [n_stages:0] vld;
    logic [width-1:0]  rad  [n_stages+1];
    logic [REM_W-1:0]  rem  [n_stages+1];
    logic [ROOT_W-1:0] root [n_stages+1];
    logic              unused_tail;

    assign vld[0]  = in_vld;
    assign rad[0]  = in_data;
    assign rem[0]  = '0;
    assign root[0] = '0;

    for (genvar g = 0; g < n_stages; g++) begin : g_stage
        isqrt_stage #(.width(width)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .vld_i  (vld[g]),
            .rad_i  (rad[g]),
            .rem_i  (rem[g]),
            .root_i (root[g]),
            .vld_o  (vld[g+1]),
            .rad_o  (rad[g+1]),
            .rem_o  (rem[g+1]),
            .root_o (root[g+1])
        );
    end

    assign out_vld  = vld[n_stages];
    assign out_data = root[n_stages];
`ifdef ISQRT_REMAINDER_EN
    assign out_rem  = rem[n_stages][ROOT_W:0];
`endif

    // The fully shifted radicand and the final remainder are dead ends unless exported.
    assign unused_tail = ^{rad[n_stages], rem[n_stages]};

endmodule

// File: doc/isqrt_pipe_with_valid.md
Name: isqrt_pipe_with_valid

Overview:
- Fully pipelined integer square root with a valid bit travelling alongside each transfer.
- Sits directly upstream of the valid-gated shift-register delay lines in the sqrt-formula pipe.
- Its fixed latency is the depth those delay lines must match, so operands (a, b, c) stay aligned with root results.
- Accepts one operand per cycle, no backpressure.

Parameters:
- width, 32, radicand width in bits; must be even and >= 4.
- n_stages, width/2 (derived localparam, not overridable), pipeline depth and latency in cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_vld  input  1  in_data is a valid radicand this cycle.
- in_data  input  width  unsigned radicand.
- out_vld  output  1  out_data holds a valid result this cycle.
- out_data  output  width/2  floor(sqrt(radicand)), unsigned.
- out_rem  output  width/2+1  radicand − out_data²; present only with ISQRT_REMAINDER_EN.

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. While rst is asserted, every stage valid bit and every stage data register clears to 0 immediately. out_vld=0, out_data=0, out_rem=0.
- Latency: exactly n_stages cycles. in_vld/in_data sampled on edge t appears on out_vld/out_data after edge t+n_stages-1 (16 cycles for width=32).
- Throughput: one transfer per cycle. No ready signal; the block never stalls.
- Valid chain: vld[0] <= in_vld; vld[k] <= vld[k-1]; out_vld = vld[n_stages-1].
- Data gating: stage k data registers load only when their incoming valid is 1, otherwise they hold. Bubbles therefore never disturb held data; out_data keeps the last valid result while out_vld=0.
- Per-stage state:
  - rad: radicand, shifted left 2 per stage.
  - rem: partial remainder, width/2+2 bits.
  - root: partial root, width/2 bits.
- Stage k operation (k=0..n_stages-1, stage 0 uses in_data, rem=0, root=0):
  - r2 = (rem << 2) | rad[width-1 -: 2]
  - trial = (root << 2) | 1
  - if r2 >= trial: rem' = r2 − trial, root' = (root << 1) | 1
  - else: rem' = r2, root' = root << 1
  - rad' = rad << 2
- Width rules: all comparisons are unsigned. trial is extended to rem width. No truncation of rem is permitted; final rem fits in width/2+1 bits.
- Exactness: out_data² <= x < (out_data+1)² for every x in [0, 2^width−1].
- Reset mid-operation: all in-flight transfers are discarded and no stale out_vld appears afterwards. The first valid after reset deasserts emerges n_stages cycles after it is accepted.
- Simultaneous events: in_vld asserted during rst is ignored.

Optional Feature:
- Macro: ISQRT_REMAINDER_EN.
- Defined: out_rem port exists and carries the final stage rem[width/2:0], aligned with out_data and out_vld, and gated and reset the same way.
- Undefined: out_rem port is absent. The remainder is still computed internally, but only its compare result is used; synthesis may trim the unused bits.

Decomposition:
- Package isqrt_pkg:
  - localparam function isqrt_latency(width) returning width/2, so downstream delay lines size their depth from it.
  - typedef for stage payload struct {rad, rem, root}, parameterised via width-sized localparams.
- Sub-module isqrt_stage:
  - One combinational-plus-register stage taking in vld/rad/rem/root and producing registered outputs.
  - Instantiated n_stages times in a generate loop.

Test Plan:
- Reset, then in_vld=1 with in_data=0 for one cycle -> out_vld=1 exactly 16 cycles later with out_data=0 (out_rem=0). out_vld=0 on all other cycles.
- in_data=32'hFFFFFFFF -> out_data=16'hFFFF, out_rem=17'h1FFFE.
- Back-to-back 1000000, 15, 16, 17 on consecutive cycles -> consecutive outputs 1000, 3, 4, 4 with out_rem 0, 6, 0, 1.
- Pattern 1,_,_,99,_ (bubbles marked _) -> outputs 1 then 9 with the same cycle spacing. out_data holds 1 while out_vld=0 between them.
- Assert rst asynchronously mid-cycle with 8 transfers in flight -> out_vld drops immediately, no output emerges for those transfers, and the next post-reset input returns after exactly 16 cycles.
- 10000 random radicands plus all squares k² and k²−1 for k=1..2^16−1 -> out_data² <= x < (out_data+1)², checked against a scoreboard.
